// File: rtl/drsstc_pkg.sv
// Shared types, field positions and clamp arithmetic for the DRSSTC interrupter.
package drsstc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      OFF  = 2'd2
   } intr_state_t;

   localparam int unsigned STORAGE_W = 16;
   localparam int unsigned CODE_W    = 8;
   localparam int unsigned TICKS_W   = 12;
   localparam int unsigned ON_MSB    = 15;
   localparam int unsigned ON_LSB    = 8;
   localparam int unsigned PER_MSB   = 7;
   localparam int unsigned PER_LSB   = 0;

   // Period length in ticks; 8-bit code shifted into a 12-bit tick count.
   function automatic logic [TICKS_W-1:0] calc_period(input logic [CODE_W-1:0] per_code,
                                                      input int unsigned       shift);
      return TICKS_W'(per_code) << shift;
   endfunction

   // On-time clamped so that at least min_off ticks of every period stay low.
   function automatic logic [TICKS_W-1:0] calc_on_eff(input logic [CODE_W-1:0]  on_code,
                                                      input logic [TICKS_W-1:0] period_ticks,
                                                      input logic [TICKS_W-1:0] min_off);
      logic [TICKS_W-1:0] room;
      if (period_ticks <= min_off) begin
         return '0;
      end
      room = period_ticks - min_off;
      return (TICKS_W'(on_code) < room) ? TICKS_W'(on_code) : room;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running timing-tick prescaler with a synchronous clear.
module tick_gen #(
   parameter int unsigned TICK_DIV = 50
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   output logic tick_o
);

   localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   logic [PW-1:0] cnt_q, cnt_d;
   logic          tick_q;

   // Next prescaler value: wrap at TICK_DIV-1, restart on clear.
   always_comb begin
      cnt_d = cnt_q + PW'(1);
      if (clr_i || (cnt_q == PW'(TICK_DIV - 1))) begin
         cnt_d = '0;
      end
   end

   // Tick is registered and high while the counter sits at its last value.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= (cnt_d == PW'(TICK_DIV - 1));
      end
   end

   assign tick_o = tick_q;

endmodule

// File: rtl/interrupter.sv
// DRSSTC interrupter: double-buffers (on-time, period) words and generates the gate pulse train.
module interrupter
   import drsstc_pkg::*;
#(
   parameter int unsigned TICK_DIV      = 50,
   parameter int unsigned PERIOD_SHIFT  = 4,
   parameter int unsigned MIN_OFF_TICKS = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [STORAGE_W-1:0] storage,
   input  logic                 is_data_ready,
   input  logic                 enable,
   output logic                 pulse_out,
   output logic                 pulse_start,
   output logic                 cfg_valid
);

   localparam logic [TICKS_W-1:0] MIN_OFF = TICKS_W'(MIN_OFF_TICKS);

   intr_state_t          state_q, state_d;
   logic                 rdy_q;
   logic [STORAGE_W-1:0] pending_q, pending_d;
   logic [STORAGE_W-1:0] active_q, active_d;
   logic                 pend_q, pend_d;
   logic [TICKS_W-1:0]   tick_cnt_q, tick_cnt_d;
   logic                 pulse_out_q, pulse_start_q, cfg_valid_q, cfg_valid_d;
   logic                 start_c, load_c, edge_c, clr_c, tick_c;
   logic [TICKS_W-1:0]   act_per_c, act_on_c, pend_per_c, pend_on_c, next_on_c;

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .clk   (clk),
      .rst   (rst),
      .clr_i (clr_c),
      .tick_o(tick_c)
   );

   assign edge_c     = is_data_ready & ~rdy_q;
   assign act_per_c  = calc_period(active_q[PER_MSB:PER_LSB], PERIOD_SHIFT);
   assign act_on_c   = calc_on_eff(active_q[ON_MSB:ON_LSB], act_per_c, MIN_OFF);
   assign pend_per_c = calc_period(pending_q[PER_MSB:PER_LSB], PERIOD_SHIFT);
   assign pend_on_c  = calc_on_eff(pending_q[ON_MSB:ON_LSB], pend_per_c, MIN_OFF);
   assign next_on_c  = pend_q ? pend_on_c : act_on_c;
   assign clr_c      = start_c && (state_q == IDLE);

   // Next-state, buffer loading and pulse timing.
   always_comb begin
      state_d     = state_q;
      tick_cnt_d  = tick_cnt_q;
      active_d    = active_q;
      cfg_valid_d = cfg_valid_q;
      load_c      = 1'b0;
      start_c     = 1'b0;
      pending_d   = edge_c ? storage : pending_q;

      case (state_q)
         IDLE: begin
            if (pend_q) begin
               load_c      = 1'b1;
               active_d    = pending_q;
               cfg_valid_d = (pend_on_c != '0);
            end
            if (enable && (next_on_c != '0)) begin
               state_d    = ON;
               tick_cnt_d = '0;
               start_c    = 1'b1;
            end
         end
         ON: begin
            if (tick_c) begin
               tick_cnt_d = tick_cnt_q + TICKS_W'(1);
               if (tick_cnt_q == act_on_c - TICKS_W'(1)) begin
                  state_d = OFF;
               end
            end
         end
         OFF: begin
            if (tick_c) begin
               tick_cnt_d = tick_cnt_q + TICKS_W'(1);
               if (tick_cnt_q == act_per_c - TICKS_W'(1)) begin
                  tick_cnt_d  = '0;
                  cfg_valid_d = (next_on_c != '0);
                  if (pend_q) begin
                     load_c   = 1'b1;
                     active_d = pending_q;
                  end
                  if (next_on_c != '0) begin
                     state_d = ON;
                     start_c = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Disarm wins over everything but keeps any pending word.
      if (!enable) begin
         state_d    = IDLE;
         tick_cnt_d = '0;
         start_c    = 1'b0;
      end

      // A fresh edge survives a same-cycle load and waits for the next one.
      pend_d = edge_c ? 1'b1 : (load_c ? 1'b0 : pend_q);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         rdy_q         <= 1'b0;
         pending_q     <= '0;
         active_q      <= '0;
         pend_q        <= 1'b0;
         tick_cnt_q    <= '0;
         pulse_out_q   <= 1'b0;
         pulse_start_q <= 1'b0;
         cfg_valid_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         rdy_q         <= is_data_ready;
         pending_q     <= pending_d;
         active_q      <= active_d;
         pend_q        <= pend_d;
         tick_cnt_q    <= tick_cnt_d;
         pulse_out_q   <= (state_d == ON);
         pulse_start_q <= start_c;
         cfg_valid_q   <= cfg_valid_d;
      end
   end

   assign pulse_out   = pulse_out_q;
   assign pulse_start = pulse_start_q;
   assign cfg_valid   = cfg_valid_q;

endmodule

// File: tb/tb_interrupter.sv
// Directed bench for the interrupter with TICK_DIV=2, PERIOD_SHIFT=4, MIN_OFF_TICKS=64.
module tb_interrupter;

   localparam int LIMIT = 2000;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] storage;
   logic        is_data_ready;
   logic        enable;
   logic        pulse_out;
   logic        pulse_start;
   logic        cfg_valid;

   int n_tests = 0;
   int n_fail  = 0;

   interrupter #(
      .TICK_DIV     (2),
      .PERIOD_SHIFT (4),
      .MIN_OFF_TICKS(64)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .storage      (storage),
      .is_data_ready(is_data_ready),
      .enable       (enable),
      .pulse_out    (pulse_out),
      .pulse_start  (pulse_start),
      .cfg_valid    (cfg_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Cycles from the current negedge until pulse_out is first seen high; -1 on timeout.
   task automatic wait_rise(output int dly);
      logic prev;
      prev = pulse_out;
      dly  = -1;
      for (int c = 1; c <= LIMIT; c++) begin
         @(negedge clk);
         is_data_ready = 1'b0;
         if (pulse_out && !prev) begin
            dly = c;
            break;
         end
         prev = pulse_out;
      end
   endtask

   // Called at a rising-edge sample: counts high cycles and cycles to the next rise,
   // optionally injecting one-cycle ready pulses with new words at given cycle offsets.
   task automatic measure(input string tag,
                          input int i1, input logic [15:0] w1,
                          input int i2, input logic [15:0] w2,
                          input int exp_hi, input int exp_per);
      int  hi;
      int  cyc;
      bit  seen_low;
      bit  ok;
      hi       = 0;
      seen_low = 0;
      ok       = 0;
      for (cyc = 0; cyc < LIMIT; cyc++) begin
         if (pulse_out) begin
            if (seen_low) begin
               ok = 1;
               break;
            end
            hi++;
         end else begin
            seen_low = 1;
         end
         is_data_ready = (cyc == i1) || (cyc == i2);
         if (cyc == i1) storage = w1;
         if (cyc == i2) storage = w2;
         @(negedge clk);
      end
      is_data_ready = 1'b0;
      check({tag, "_found_rise"}, int'(ok), 1);
      check({tag, "_high_clks"}, hi, exp_hi);
      check({tag, "_period_clks"}, cyc, exp_per);
      check({tag, "_pulse_start"}, int'(pulse_start), 1);
   endtask

   initial begin
      int d;
      int cnt;

      // Reset state
      rst           = 1'b1;
      storage       = '0;
      is_data_ready = 1'b0;
      enable        = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_pulse_out", int'(pulse_out), 0);
      check("rst_pulse_start", int'(pulse_start), 0);
      check("rst_cfg_valid", int'(cfg_valid), 0);
      rst = 1'b0;
      @(negedge clk);

      // 1: on=10 ticks, period=128 ticks -> 20 clks high, 256 clks period
      storage       = 16'h0A08;
      is_data_ready = 1'b1;
      enable        = 1'b1;
      wait_rise(d);
      check("t1_latency", d, 2);
      check("t1_pulse_start", int'(pulse_start), 1);
      check("t1_cfg_valid", int'(cfg_valid), 1);
      measure("t1_p1", -1, '0, -1, '0, 20, 256);
      measure("t1_p2", -1, '0, -1, '0, 20, 256);

      // 2: on code 255 clamped to 64 ticks; applied only from the next period
      measure("t2_cur", 3, 16'hFF08, -1, '0, 20, 256);
      measure("t2_new", -1, '0, -1, '0, 128, 256);
      check("t2_cfg_valid", int'(cfg_valid), 1);

      // 4: two words in one period, the last one (on=20 ticks) wins
      measure("t4_cur", 5, 16'h0A08, 100, 16'h1408, 128, 256);
      measure("t4_new", -1, '0, -1, '0, 40, 256);

      // 3: period 64 ticks leaves no on-time; current 40-clk pulse finishes, then silence
      storage       = 16'h0A04;
      is_data_ready = 1'b1;
      cnt           = 0;
      for (int c = 0; c < 600; c++) begin
         if (pulse_out) cnt++;
         if (c == 200) check("t3_cfg_before_load", int'(cfg_valid), 1);
         @(negedge clk);
         is_data_ready = 1'b0;
      end
      check("t3_high_clks", cnt, 40);
      check("t3_cfg_valid", int'(cfg_valid), 0);
      check("t3_pulse_out", int'(pulse_out), 0);

      // 5: drop enable mid-pulse, then re-arm for a fresh period
      storage       = 16'h0A08;
      is_data_ready = 1'b1;
      wait_rise(d);
      check("t5_latency", d, 2);
      repeat (5) @(negedge clk);
      check("t5_mid_pulse", int'(pulse_out), 1);
      enable = 1'b0;
      @(negedge clk);
      check("t5_disable_off", int'(pulse_out), 0);
      repeat (4) @(negedge clk);
      check("t5_still_off", int'(pulse_out), 0);
      check("t5_cfg_kept", int'(cfg_valid), 1);
      enable = 1'b1;
      @(negedge clk);
      check("t5_reenable_on", int'(pulse_out), 1);
      check("t5_reenable_start", int'(pulse_start), 1);
      measure("t5_fresh", -1, '0, -1, '0, 20, 256);

      // 6: reset mid-pulse drops everything
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("t6_pulse_out", int'(pulse_out), 0);
      check("t6_cfg_valid", int'(cfg_valid), 0);
      check("t6_pulse_start", int'(pulse_start), 0);
      rst = 1'b0;
      cnt = 0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (pulse_out) cnt++;
      end
      check("t6_no_pulses", cnt, 0);
      storage       = 16'h0A08;
      is_data_ready = 1'b1;
      wait_rise(d);
      check("t6_restart_latency", d, 2);
      check("t6_restart_cfg", int'(cfg_valid), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
